// File: rtl/idex_pkg.sv
// ID/EX stage shared constants: control-word layout and the NOP control value.
package idex_pkg;

  localparam int CTRL_W = 8;

  // Control bit positions inside the packed control word.
  localparam int CTRL_REGDST   = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_ALUOP_HI = 4;
  localparam int CTRL_ALUOP_LO = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_REGWRITE = 0;

  // ALUOp is a 2-bit field starting at CTRL_ALUOP_LO.
  localparam int ALUOP_W = CTRL_ALUOP_HI - CTRL_ALUOP_LO + 1;

  // Bubble control: no register or memory write, nothing architecturally visible.
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  // Extract the ALUOp field from a control word.
  function automatic logic [ALUOP_W-1:0] ctrl_aluop(input logic [CTRL_W-1:0] c);
    return c[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: main entry drives the output, skid entry
// absorbs the one extra beat that arrives while the output is stalled.
module pipe_skid_buf #(
  parameter int PAY_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PAY_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PAY_W-1:0] out_data
);

  logic [PAY_W-1:0] main_q, main_d, skid_q, skid_d;
  logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic             accept, drain;

  // Skid only fills while main is full, so !skid_vld is the free-slot flag.
  assign in_ready  = !skid_vld_q;
  assign out_valid = main_vld_q;
  assign out_data  = main_q;
  assign accept    = in_valid && in_ready;
  assign drain     = main_vld_q && out_ready;

  // Next-state: keep FIFO order, refill main from skid before taking new input.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || drain) begin
      if (skid_vld_q) begin
        // in_ready is low here, so no same-cycle accept can compete.
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = in_data;
      end
    end else if (accept) begin
      skid_d     = in_data;
      skid_vld_d = 1'b1;
    end
  end

  // State registers; reset clears payload as well as valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

endmodule

// File: rtl/idex_skid_stage.sv
// ID/EX pipeline register with valid/ready flow control, skid buffering,
// flush, bubble-masked control and a saturating stall counter.
module idex_skid_stage #(
  parameter int DATA_W = 32,
  parameter int RID_W  = 5,
  parameter int CTRL_W = idex_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RID_W-1:0]  in_rs,
  input  logic [RID_W-1:0]  in_rt,
  input  logic [RID_W-1:0]  in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_read1,
  input  logic [DATA_W-1:0] in_read2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RID_W-1:0]  out_rs,
  output logic [RID_W-1:0]  out_rt,
  output logic [RID_W-1:0]  out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_read1,
  output logic [DATA_W-1:0] out_read2,
  output logic [CNT_W-1:0]  stall_cnt
);
  import idex_pkg::*;

  localparam int PAY_W = 3*RID_W + CTRL_W + 3*DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAY_W-1:0]  pay_in, pay_out;
  logic [CTRL_W-1:0] ctrl_raw;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign pay_in = {in_rs, in_rt, in_rd, in_ctrl, in_imm, in_read1, in_read2};

  pipe_skid_buf #(.PAY_W(PAY_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out)
  );

  assign {out_rs, out_rt, out_rd, ctrl_raw, out_imm, out_read1, out_read2} = pay_out;

  // Payload may be stale after a flush; only the control word is guaranteed clean.
  assign out_ctrl = out_valid ? ctrl_raw : CTRL_NOP[CTRL_W-1:0];

  // Stall counter next value: count held-but-not-taken cycles, stick at max.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
  end

  // Stall counter register; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_idex_skid_stage.sv
// Self-checking bench for idex_skid_stage: directed table, corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_idex_skid_stage;

  localparam int DATA_W = 32;
  localparam int RID_W  = 5;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [RID_W-1:0]  rs, rt, rd;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] imm, r1, r2;
  } pay_t;

  typedef struct {
    bit          iv, ordy;
    logic [31:0] imm;
    bit          eov, eir;
    logic [31:0] eimm;
    logic [7:0]  ectrl;
    int          ecnt;
  } vec_t;

  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [RID_W-1:0]  in_rs = 0, in_rt = 0, in_rd = 0, out_rs, out_rt, out_rd;
  logic [CTRL_W-1:0] in_ctrl = 0, out_ctrl;
  logic [DATA_W-1:0] in_imm = 0, in_read1 = 0, in_read2 = 0, out_imm, out_read1, out_read2;
  logic [CNT_W-1:0]  stall_cnt;
  pay_t dut_pay;

  int total = 0, bad = 0;
  pay_t mq[$];
  int   mcnt;

  always #5 clk = ~clk;

  idex_skid_stage #(.DATA_W(DATA_W), .RID_W(RID_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_ctrl(in_ctrl), .in_imm(in_imm),
    .in_read1(in_read1), .in_read2(in_read2), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_ctrl(out_ctrl), .out_imm(out_imm),
    .out_read1(out_read1), .out_read2(out_read2), .stall_cnt(stall_cnt)
  );

  assign dut_pay = '{rs: out_rs, rt: out_rt, rd: out_rd, ctrl: out_ctrl,
                     imm: out_imm, r1: out_read1, r2: out_read2};

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic pay_t mk(input logic [31:0] imm, input logic [7:0] ctrl);
    pay_t p;
    p.rs = imm[4:0]; p.rt = imm[4:0] ^ 5'h1f; p.rd = imm[4:0] + 5'd3;
    p.ctrl = ctrl; p.imm = imm; p.r1 = ~imm; p.r2 = imm * 32'd7 + 32'd1;
    return p;
  endfunction

  function automatic pay_t rnd_pay();
    pay_t p;
    p.rs = 5'($urandom); p.rt = 5'($urandom); p.rd = 5'($urandom);
    p.ctrl = 8'($urandom); p.imm = $urandom; p.r1 = $urandom; p.r2 = $urandom;
    return p;
  endfunction

  // Compare DUT outputs with the FIFO model of what should be held.
  task automatic mchk();
    bit mv;
    mv = (mq.size() > 0);
    chk("m_out_valid", 192'(out_valid), 192'(mv));
    chk("m_in_ready", 192'(in_ready), 192'(mq.size() < 2));
    chk("m_out_ctrl", 192'(out_ctrl), mv ? 192'(mq[0].ctrl) : 192'(0));
    chk("m_stall_cnt", 192'(stall_cnt), 192'(mcnt));
    if (mv) chk("m_payload", 192'(dut_pay), 192'(mq[0]));
  endtask

  // Apply inputs for one cycle, check pre-edge state, advance model past the edge.
  task automatic step(input bit r, input bit fl, input bit iv, input bit ordy, input pay_t p);
    bit acc, drn, stl;
    rst = r; flush = fl; in_valid = iv; out_ready = ordy;
    in_rs = p.rs; in_rt = p.rt; in_rd = p.rd; in_ctrl = p.ctrl;
    in_imm = p.imm; in_read1 = p.r1; in_read2 = p.r2;
    mchk();
    acc = iv && (mq.size() < 2);
    drn = (mq.size() > 0) && ordy;
    stl = (mq.size() > 0) && !ordy;
    @(posedge clk); #1;
    if (r) begin
      mq.delete(); mcnt = 0;
    end else begin
      if (stl && mcnt < CMAX) mcnt++;
      if (fl) mq.delete();
      else begin
        if (drn) void'(mq.pop_front());
        if (acc) mq.push_back(p);
      end
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, mk(0, 0));
    step(0, 0, 0, 1, mk(0, 0));
  endtask

  vec_t tbl[8];

  initial begin
    // Backpressure sequence: A,B,C with 3 stalled cycles, then release.
    tbl[0] = '{1, 0, 32'hA, 0, 1, 32'h0, 8'h00, 0};
    tbl[1] = '{1, 0, 32'hB, 1, 1, 32'hA, 8'h5A, 0};
    tbl[2] = '{1, 0, 32'hC, 1, 0, 32'hA, 8'h5A, 1};
    tbl[3] = '{1, 0, 32'hC, 1, 0, 32'hA, 8'h5A, 2};
    tbl[4] = '{1, 1, 32'hC, 1, 0, 32'hA, 8'h5A, 3};
    tbl[5] = '{1, 1, 32'hC, 1, 1, 32'hB, 8'h5A, 3};
    tbl[6] = '{0, 1, 32'h0, 1, 1, 32'hC, 8'h5A, 3};
    tbl[7] = '{0, 1, 32'h0, 0, 1, 32'h0, 8'h00, 3};

    // First reset edge without checks (outputs are X before it).
    @(posedge clk); #1;
    mq.delete(); mcnt = 0;
    rst = 0;
    chk("rst_out_valid", 192'(out_valid), 192'(0));
    chk("rst_in_ready", 192'(in_ready), 192'(1));
    chk("rst_out_ctrl", 192'(out_ctrl), 192'(0));
    chk("rst_stall_cnt", 192'(stall_cnt), 192'(0));
    chk("rst_payload", 192'(dut_pay), 192'(0));

    // Streaming: 10 back-to-back, one per cycle, 1-cycle latency.
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        chk("stream_valid", 192'(out_valid), 192'(1));
        chk("stream_imm", 192'(out_imm), 192'(i - 1));
      end
      chk("stream_in_ready", 192'(in_ready), 192'(1));
      step(0, 0, i < 10, 1, mk(32'(i), 8'h5A));
    end
    chk("stream_empty", 192'(out_valid), 192'(0));
    chk("stream_cnt", 192'(stall_cnt), 192'(0));

    // Table-driven backpressure.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk("tbl_out_valid", 192'(out_valid), 192'(tbl[i].eov));
      chk("tbl_in_ready", 192'(in_ready), 192'(tbl[i].eir));
      chk("tbl_out_ctrl", 192'(out_ctrl), 192'(tbl[i].ectrl));
      chk("tbl_stall_cnt", 192'(stall_cnt), 192'(tbl[i].ecnt));
      if (tbl[i].eov) chk("tbl_out_imm", 192'(out_imm), 192'(tbl[i].eimm));
      step(0, 0, tbl[i].iv, tbl[i].ordy, mk(tbl[i].imm, 8'h5A));
    end

    // Flush with full skid and an incoming C.
    do_reset();
    step(0, 0, 1, 0, mk(32'hA, 8'hFF));
    step(0, 0, 1, 0, mk(32'hB, 8'hFF));
    chk("fl_skid_full", 192'(in_ready), 192'(0));
    step(0, 1, 1, 0, mk(32'hC, 8'hFF));
    chk("fl_out_valid", 192'(out_valid), 192'(0));
    chk("fl_out_ctrl", 192'(out_ctrl), 192'(0));
    chk("fl_in_ready", 192'(in_ready), 192'(1));
    chk("fl_cnt_kept", 192'(stall_cnt), 192'(2));
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, mk(0, 0));
      chk("fl_nothing_out", 192'(out_valid), 192'(0));
    end

    // Bubble masking: ctrl=FF drained, then zero.
    do_reset();
    step(0, 0, 1, 1, mk(32'h77, 8'hFF));
    chk("bub_ctrl_live", 192'(out_ctrl), 192'(8'hFF));
    step(0, 0, 0, 1, mk(0, 0));
    chk("bub_out_valid", 192'(out_valid), 192'(0));
    chk("bub_ctrl_zero", 192'(out_ctrl), 192'(0));

    // Saturation: 20 stalled cycles on a 4-bit counter.
    do_reset();
    step(0, 0, 1, 0, mk(32'h5, 8'h01));
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, mk(0, 0));
    chk("sat_cnt", 192'(stall_cnt), 192'(15));
    step(0, 0, 0, 0, mk(0, 0));
    chk("sat_hold", 192'(stall_cnt), 192'(15));

    // Reset mid-stall with both entries full, input still valid.
    do_reset();
    step(0, 0, 1, 0, mk(32'h11, 8'hFF));
    step(0, 0, 1, 0, mk(32'h22, 8'hFF));
    step(1, 0, 1, 0, mk(32'h33, 8'hFF));
    chk("rst2_out_valid", 192'(out_valid), 192'(0));
    chk("rst2_in_ready", 192'(in_ready), 192'(1));
    chk("rst2_out_ctrl", 192'(out_ctrl), 192'(0));
    chk("rst2_stall_cnt", 192'(stall_cnt), 192'(0));
    chk("rst2_payload", 192'(dut_pay), 192'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 6,
           rnd_pay());
    end
    mchk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
